text_scroller: RTL and testbench

- Generates the scrolling 8-character window that the menu's seven-segment display driver renders; one instance per menu message (balance, withdraw, currency, transfer).
- Runs on the system clock with an internal step divider, replacing the derived one-second clock.
- Walks a fixed-length message through an 8-digit window: holds at the start, scrolls left one character per step, then wraps.
- Output is the packed 40-bit character word the display driver consumes.

---
 rtl/text_scroller.sv | 135 +++++++++++++
 tb/tb_text_scroller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/text_scroller.sv
// rtl/text_scroller.sv - scrolling WIN-character window over a blank-padded message.
// Optional reverse scrolling with a dir input is enabled by defining TEXT_SCROLLER_DIR_EN.
module text_scroller #(
  parameter int MSG_LEN    = 16,
  parameter int CHAR_W     = 5,
  parameter int WIN        = 8,
  parameter int TICK_DIV   = 100000000,
  parameter int HOLD_STEPS = 2,
  parameter int BLANK_CODE = 31
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      restart,
`ifdef TEXT_SCROLLER_DIR_EN
  input  logic                      dir,
`endif
  input  logic [MSG_LEN*CHAR_W-1:0] msg,
  output logic [WIN*CHAR_W-1:0]     window,
  output logic                      wrap
);

  localparam int L      = MSG_LEN + WIN;
  localparam int OFF_W  = $clog2(L);
  localparam int SUM_W  = OFF_W + 1;
  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(HOLD_STEPS + 1);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(L - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  typedef enum logic {S_HOLD, S_SCROLL} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [OFF_W-1:0]       off_q, off_d;
  logic                   wrap_q, wrap_d;
  logic [WIN*CHAR_W-1:0]  window_q, window_d;
  logic                   tick;
  logic                   load;
  logic                   back;
  logic [SUM_W-1:0]       sum;
  logic [CHAR_W-1:0]      stream [L];

  for (genvar k = 0; k < L; k++) begin : g_stream
    if (k < MSG_LEN) begin : g_msg
      assign stream[k] = msg[k*CHAR_W +: CHAR_W];
    end else begin : g_pad
      assign stream[k] = CHAR_W'(BLANK_CODE);
    end
  end

`ifdef TEXT_SCROLLER_DIR_EN
  assign back = dir;
`else
  assign back = 1'b0;
`endif

  assign tick = en && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    off_d   = off_q;
    wrap_d  = 1'b0;
    load    = 1'b0;
    if (rst || restart) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      hold_d  = '0;
      off_d   = '0;
      load    = 1'b1;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        load = 1'b1;
        case (state_q)
          S_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = S_SCROLL;
            else                     hold_d  = hold_q + 1'b1;
          end
          S_SCROLL: begin
            // Reverse scrolling leaves offset 0 by jumping to the last stream position.
            if (back ? (off_q == OFF_W'(1)) : (off_q == OFF_LAST)) begin
              off_d   = '0;
              hold_d  = '0;
              state_d = S_HOLD;
              wrap_d  = 1'b1;
            end else if (back) begin
              off_d = (off_q == '0) ? OFF_LAST : off_q - 1'b1;
            end else begin
              off_d = off_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    window_d = window_q;
    sum      = '0;
    if (load) begin
      for (int i = 0; i < WIN; i++) begin
        sum = {1'b0, off_d} + SUM_W'(i);
        if (sum >= SUM_W'(L)) sum = sum - SUM_W'(L);
        window_d[(WIN-1-i)*CHAR_W +: CHAR_W] = stream[sum[OFF_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      hold_q   <= '0;
      off_q    <= '0;
      wrap_q   <= 1'b0;
      window_q <= window_d;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      off_q    <= off_d;
      wrap_q   <= wrap_d;
      window_q <= window_d;
    end
  end

  assign window = window_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_text_scroller.sv
// tb/tb_text_scroller.sv - scoreboard bench for text_scroller (4-char message, 3-cycle steps).
module tb_text_scroller;
  localparam int MSG_LEN = 4;
  localparam int CHAR_W = 5;
  localparam int WIN = 8;
  localparam int TICK_DIV = 3;
  localparam int HOLD_STEPS = 2;
  localparam int BLANK = 31;
  localparam int L = MSG_LEN + WIN;

  localparam logic [39:0] W0 = {5'd1, 5'd2, 5'd3, 5'd4, 5'd31, 5'd31, 5'd31, 5'd31};
  localparam logic [39:0] W1 = {5'd2, 5'd3, 5'd4, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
  localparam logic [39:0] W2 = {5'd3, 5'd4, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
  localparam logic [39:0] W6 = {5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd1, 5'd2};
  localparam logic [39:0] WN = {5'd8, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
  localparam logic [39:0] WR = {5'd31, 5'd1, 5'd2, 5'd3, 5'd4, 5'd31, 5'd31, 5'd31};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, restart, dir;
  logic [19:0] msg;
  logic [39:0] window;
  logic        wrap;

  text_scroller #(
    .MSG_LEN(MSG_LEN), .CHAR_W(CHAR_W), .WIN(WIN), .TICK_DIV(TICK_DIV),
    .HOLD_STEPS(HOLD_STEPS), .BLANK_CODE(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .restart(restart),
`ifdef TEXT_SCROLLER_DIR_EN
    .dir(dir),
`endif
    .msg(msg),
    .window(window),
    .wrap(wrap)
  );

  typedef struct {
    logic [39:0] win;
    logic        wrap;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          m_div = 0, m_hold = 0, m_off = 0;
  bit          m_scroll = 0;
  bit          dir_eff = 0;
  logic [39:0] m_win = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [39:0] exp_win(input int off, input logic [19:0] m);
    logic [39:0] w;
    int j;
    w = '0;
    for (int i = 0; i < WIN; i++) begin
      j = (off + i) % L;
      w[(WIN-1-i)*CHAR_W +: CHAR_W] = (j < MSG_LEN) ? m[j*CHAR_W +: CHAR_W] : 5'(BLANK);
    end
    return w;
  endfunction

  // One clock: predict the post-edge outputs, push them, then compare on the falling edge.
  task automatic step();
    exp_t e;
    bit   t;
    bit   w;
    w = 0;
    if (rst || restart) begin
      m_div = 0; m_hold = 0; m_off = 0; m_scroll = 0;
      m_win = exp_win(0, msg);
    end else if (en) begin
      t = (m_div == TICK_DIV - 1);
      m_div = t ? 0 : m_div + 1;
      if (t) begin
        if (!m_scroll) begin
          if (m_hold == HOLD_STEPS - 1) m_scroll = 1;
          else m_hold++;
        end else begin
          m_off = dir_eff ? (m_off + L - 1) % L : (m_off + 1) % L;
          if (m_off == 0) begin
            w = 1; m_scroll = 0; m_hold = 0;
          end
        end
        m_win = exp_win(m_off, msg);
      end
    end
    e.win = m_win;
    e.wrap = w;
    exp_q.push_back(e);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("sb_window", window, e.win);
      check_val("sb_wrap", wrap, e.wrap);
    end
  endtask

  task automatic wait_for(input int off, input int div, input string tag);
    int n;
    n = 0;
    while (!(m_off == off && (div < 0 || m_div == div)) && n < 100) begin
      step();
      n++;
    end
    check_val(tag, (n < 100), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int          nwrap;
  int          wrap_cyc;
  logic [39:0] saved;

  initial begin
    rst = 1; restart = 0; en = 1; dir = 0;
    msg = {5'd4, 5'd3, 5'd2, 5'd1};
    @(negedge clk);
    step();
    rst = 0;
    cyc = 0;
    check_val("rst_window", window, W0);
    check_val("rst_wrap", wrap, 0);

    for (int i = 1; i <= 6; i++) begin
      step();
      check_val("t1_hold", window, W0);
    end
    while (cyc < 9) step();
    check_val("t1_step", window, W1);

    nwrap = 0; wrap_cyc = 0;
    while (cyc < 42) begin
      step();
      if (wrap) begin nwrap++; wrap_cyc = cyc; end
    end
    check_val("t2_wrap_cnt", nwrap, 1);
    check_val("t2_wrap_cyc", wrap_cyc, 42);
    check_val("t2_window", window, W0);

    wait_for(5, 1, "t3_reach");
    saved = window;
    en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("t3_frozen", window, saved);
      check_val("t3_nowrap", wrap, 0);
    end
    en = 1;
    step();
    check_val("t3_resume1", window, saved);
    step();
    check_val("t3_resume2", window, W6);

    wait_for(7, -1, "t4_reach");
    restart = 1;
    step();
    restart = 0;
    check_val("t4_window", window, W0);
    check_val("t4_wrap", wrap, 0);
    for (int i = 1; i <= 8; i++) step();
    check_val("t4_hold", window, W0);
    step();
    check_val("t4_step", window, W1);

    wait_for(2, 1, "t5_reach");
    check_val("t5_pre", window, W2);
    msg = {5'd8, 5'd7, 5'd6, 5'd5};
    step();
    check_val("t5_hold", window, W2);
    step();
    check_val("t5_new", window, WN);

`ifdef TEXT_SCROLLER_DIR_EN
    msg = {5'd4, 5'd3, 5'd2, 5'd1};
    dir = 1; dir_eff = 1; rst = 1;
    step();
    rst = 0;
    cyc = 0;
    while (cyc < 9) step();
    check_val("d_step", window, WR);
    nwrap = 0; wrap_cyc = 0;
    while (cyc < 42) begin
      step();
      if (wrap) begin nwrap++; wrap_cyc = cyc; end
    end
    check_val("d_wrap_cnt", nwrap, 1);
    check_val("d_wrap_cyc", wrap_cyc, 42);
    check_val("d_window", window, W0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
